serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer that sits directly upstream of the gate-level 1-bit full adder `addbit`. It accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake. It presents one bit pair per clock, LSB first, to `addbit` on add_a/add_b/add_ci, and collects add_sum/add_co back. Carry is held in a flop between cycles; the assembled WIDTH-bit sum and carry-out are returned over a second valid/ready handshake.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.
CNT_W, 6, counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands valid.
in_ready  output  1  block can accept operands.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_ci  input  1  carry-in.
add_a  output  1  bit to addbit.a.
add_b  output  1  bit to addbit.b.
add_ci  output  1  carry to addbit.ci.
add_sum  input  1  from addbit.sum (combinational).
add_co  input  1  from addbit.co (combinational).
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
out_sum  output  WIDTH  sum result.
out_co  output  1  final carry-out.
busy  output  1  high while in RUN.

Behaviour:
- One clock domain. Reset is asynchronous and active-low (rst_n). All state registers reset asynchronously; no synchronous reset.
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values:
  - in_ready=1, out_valid=0, busy=0.
  - out_sum=0, out_co=0.
  - add_a=0, add_b=0, add_ci=0.
- Decode from state:
  - in_ready=1 only in IDLE.
  - busy=1 only in RUN.
  - out_valid=1 only in DONE.
- IDLE: when in_valid && in_ready at a clock edge:
  - load sh_a<=in_a, sh_b<=in_b, carry<=in_ci.
  - clear res<=0 and cnt<=0.
  - go to RUN.
  - in_a, in_b and in_ci are sampled only on this edge.
- RUN, each cycle:
  - add_a=sh_a[0], add_b=sh_b[0], add_ci=carry. These are driven directly from registers, with no combinational path from in_*.
  - At the edge: res<={add_sum, res[WIDTH-1:1]}, carry<=add_co, sh_a>>=1, sh_b>>=1, cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge, go to DONE instead of staying in RUN.
- Latency: exactly WIDTH cycles in RUN. out_valid rises WIDTH edges after the accepting edge.
- DONE:
  - out_sum=res and out_co=carry, both held stable.
  - add_a/add_b/add_ci=0.
  - When out_ready is high at an edge, go to IDLE.
  - While out_ready is low, hold indefinitely with all outputs unchanged.
- No result/accept overlap: a new operand is accepted no earlier than the edge after the DONE→IDLE transition. So minimum throughput is one add per WIDTH+2 cycles.
- in_valid is ignored in RUN and DONE; operand registers must not change.
- out_ready is ignored outside DONE.
- Outside RUN, add_a/add_b/add_ci are 0.
- out_sum/out_co in IDLE and RUN show the register contents. Consumers must qualify them with out_valid only.
- Arithmetic: {out_co,out_sum} = in_a + in_b + in_ci, computed modulo 2**(WIDTH+1). No separate overflow flag.
- Reset mid-operation (RUN or DONE):
  - immediately go to IDLE and restore all reset values.
  - the partial result is discarded and no out_valid is produced.
- WIDTH=1: RUN lasts one cycle; the cnt==0 terminal condition applies on the first edge.
- Counter never wraps: it is cleared on accept and stops at WIDTH-1.

Test Plan:
- WIDTH=8, in_a=0x5A, in_b=0x3C, in_ci=0, out_ready=1 → out_valid rises 8 edges after accept with out_sum=0x96, out_co=0. Monitor add_a serial stream = 0,1,0,1,1,0,1,0 (LSB first).
- in_a=0xFF, in_b=0x01, in_ci=0 → out_sum=0x00, out_co=1. in_a=0xFF, in_b=0xFF, in_ci=1 → out_sum=0xFF, out_co=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid stays 1 and out_sum/out_co are constant. On out_ready=1, IDLE is entered the next edge and in_ready=1.
- Pulse in_valid with in_a=0x11 during RUN → ignored; the original result completes unchanged and no second result appears.
- Assert rst_n=0 on the 3rd RUN cycle (asynchronous, mid-cycle) → outputs return immediately to reset values, with no out_valid. After release, a fresh 0x01+0x01 returns 0x02.
- Run with WIDTH=1, all 8 combinations of a/b/ci → each completes in 1 RUN cycle with {out_co,out_sum} = a+b+ci. Then run 200 random back-to-back adds at WIDTH=8 against a reference model.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer that feeds a 1-bit full adder LSB first
// and collects the WIDTH-bit sum and the final carry-out.
module serial_add_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_ci,
   output logic             add_a,
   output logic             add_b,
   output logic             add_ci,
   input  logic             add_sum,
   input  logic             add_co,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_co,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sh_a_q, sh_a_d;
   logic [WIDTH-1:0] sh_b_q, sh_b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         sh_a_q  <= '0;
         sh_b_q  <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_a_q  <= sh_a_d;
         sh_b_q  <= sh_b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sh_a_d  = sh_a_q;
      sh_b_d  = sh_b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               sh_a_d  = in_a;
               sh_b_d  = in_b;
               carry_d = in_ci;
               res_d   = '0;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
            res_d            = res_q >> 1;
            res_d[WIDTH-1]   = add_sum;
            carry_d          = add_co;
            sh_a_d           = sh_a_q >> 1;
            sh_b_d           = sh_b_q >> 1;
            if (cnt_q == LastCnt) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == StIdle);
      busy      = (state_q == StRun);
      out_valid = (state_q == StDone);
      add_a     = busy & sh_a_q[0];
      add_b     = busy & sh_b_q[0];
      add_ci    = busy & carry_q;
      out_sum   = res_q;
      out_co    = carry_q;
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances, each driving a
// behavioural full adder, checked against a scoreboard of a+b+ci results.
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       in_valid = 1'b0, in_ready, in_ci = 1'b0;
   logic [7:0] in_a = '0, in_b = '0, out_sum;
   logic       add_a, add_b, add_ci, add_sum, add_co;
   logic       out_valid, out_ready = 1'b1, out_co, busy;

   logic       in_valid1 = 1'b0, in_ready1, in_ci1 = 1'b0;
   logic [0:0] in_a1 = '0, in_b1 = '0, out_sum1;
   logic       add_a1, add_b1, add_ci1, add_sum1, add_co1;
   logic       out_valid1, out_co1, busy1;

   int checks = 0;
   int errors = 0;
   logic [8:0] sb[$];

   always #5 clk = ~clk;

   // Behavioural 1-bit full adders standing in for addbit.
   assign add_sum  = add_a ^ add_b ^ add_ci;
   assign add_co   = (add_a & add_b) | (add_a & add_ci) | (add_b & add_ci);
   assign add_sum1 = add_a1 ^ add_b1 ^ add_ci1;
   assign add_co1  = (add_a1 & add_b1) | (add_a1 & add_ci1) | (add_b1 & add_ci1);

   serial_add_ctrl #(.WIDTH(8), .CNT_W(6)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .add_a(add_a), .add_b(add_b),
      .add_ci(add_ci), .add_sum(add_sum), .add_co(add_co), .out_valid(out_valid),
      .out_ready(out_ready), .out_sum(out_sum), .out_co(out_co), .busy(busy)
   );

   serial_add_ctrl #(.WIDTH(1), .CNT_W(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_a(in_a1), .in_b(in_b1), .in_ci(in_ci1), .add_a(add_a1), .add_b(add_b1),
      .add_ci(add_ci1), .add_sum(add_sum1), .add_co(add_co1), .out_valid(out_valid1),
      .out_ready(out_ready), .out_sum(out_sum1), .out_co(out_co1), .busy(busy1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic do_add8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input int stall, input bit poke, input string tag);
      logic [8:0] expv;
      logic [8:0] got;
      logic [7:0] stream;
      int n;
      out_ready = (stall == 0);
      in_a = a; in_b = b; in_ci = ci; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk);
      sb.push_back({1'b0, a} + {1'b0, b} + 9'(ci));
      @(negedge clk);
      in_valid = 1'b0;
      in_a = 8'($urandom); in_b = 8'($urandom); in_ci = 1'($urandom);
      n = 0; stream = '0;
      while (!out_valid && n < 20) begin
         if (busy && n < 8) stream[n] = add_a;
         if (poke && n == 1) begin in_valid = 1'b1; in_a = 8'h11; end
         else in_valid = 1'b0;
         @(negedge clk); n++;
      end
      check({tag, " latency"}, 32'(n), 32'd8);
      check({tag, " add_a stream"}, 32'(stream), 32'(a));
      expv = (sb.size() > 0) ? sb.pop_front() : 9'bx;
      got = {out_co, out_sum};
      check({tag, " result"}, 32'(got), 32'(expv));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
         check({tag, " stall result"}, 32'({out_co, out_sum}), 32'(expv));
      end
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, " back to idle"}, 32'({in_ready, out_valid, busy}), 32'b100);
   endtask

   task automatic do_add1(input logic a, input logic b, input logic ci);
      int n;
      in_a1 = a; in_b1 = b; in_ci1 = ci; in_valid1 = 1'b1;
      n = 0;
      while (!in_ready1 && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      sb.push_back(9'(a) + 9'(b) + 9'(ci));
      @(negedge clk);
      in_valid1 = 1'b0;
      check("w1 busy", 32'(busy1), 32'd1);
      n = 0;
      while (!out_valid1 && n < 10) begin @(negedge clk); n++; end
      check("w1 latency", 32'(n), 32'd1);
      check("w1 result", 32'({out_co1, out_sum1}),
            32'((sb.size() > 0) ? sb.pop_front() : 9'bx));
      @(negedge clk);
      check("w1 idle", 32'(in_ready1), 32'd1);
   endtask

   initial begin
      bit seen;
      #1;
      check("reset ctl", 32'({in_ready, out_valid, busy}), 32'b100);
      check("reset out", 32'({out_co, out_sum}), 32'd0);
      check("reset add", 32'({add_a, add_b, add_ci}), 32'd0);
      check("reset w1", 32'({in_ready1, out_valid1, busy1}), 32'b100);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_add8(8'h5A, 8'h3C, 1'b0, 0, 1'b0, "5a+3c");
      do_add8(8'hFF, 8'h01, 1'b0, 0, 1'b0, "ff+01");
      do_add8(8'hFF, 8'hFF, 1'b1, 0, 1'b0, "ff+ff+1");
      do_add8(8'h81, 8'h7E, 1'b1, 5, 1'b0, "stall");
      do_add8(8'h23, 8'h45, 1'b0, 0, 1'b1, "poke");
      seen = 1'b0;
      repeat (12) begin @(negedge clk); seen |= out_valid; end
      check("poke no 2nd result", 32'(seen), 32'd0);

      // Asynchronous reset in the third RUN cycle.
      in_a = 8'hFF; in_b = 8'hFF; in_ci = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk); @(negedge clk);
      check("pre-reset busy", 32'({busy, add_ci}), 32'b11);
      #2 rst_n = 1'b0;
      #1;
      check("mid reset ctl", 32'({in_ready, out_valid, busy}), 32'b100);
      check("mid reset out", 32'({out_co, out_sum}), 32'd0);
      check("mid reset add", 32'({add_a, add_b, add_ci}), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin @(negedge clk); seen |= out_valid; end
      check("no out after reset", 32'(seen), 32'd0);
      do_add8(8'h01, 8'h01, 1'b0, 0, 1'b0, "post-reset");

      for (int i = 0; i < 8; i++) do_add1(i[2], i[1], i[0]);

      for (int i = 0; i < 200; i++)
         do_add8(8'($urandom), 8'($urandom), 1'($urandom), 0, 1'b0, "rand");

      check("scoreboard empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
